step_sequencer: RTL
===================

# step_sequencer

Pattern controller for the tone datapath. It holds a programmable pattern of NUM_STEPS note slots and steps through them at a fixed tempo while `run` is high. For each step it presents a 3-bit note code and a gate to the note decoder / PWM generator. The gate is dropped for a programmable gap at the end of every step, so that repeated notes articulate.

## Interface
Parameters:
- NUM_STEPS, 8: pattern length; power of two, 2..16.
- STEP_TICKS, 3_000_000: clock cycles per step (250 ms at 12 MHz); at least 2.
- GAP_TICKS, 300_000: silent cycles at the end of each step; 0 <= GAP_TICKS < STEP_TICKS.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = play pattern, 0 = stop and rewind.
- wr_en  in  1  pattern write strobe, one cycle per write.
- wr_addr  in  $clog2(NUM_STEPS)  step slot to write.
- wr_note  in  3  note code for the slot (decoder encoding).
- wr_on  in  1  slot enable; 0 = rest.
- note  out  3  note code of current step, to the decoder.
- gate  out  1  1 = tone audible; drives the PWM output enable.
- step_idx  out  $clog2(NUM_STEPS)  index of current step.
- step_pulse  out  1  single-cycle strobe on entry to every step.

## Operation
- Pattern RAM: NUM_STEPS entries of {on, note[2:0]}. Reset clears every entry to {0, 3'b000}. Writes are accepted in any state.
- FSM states:
  - IDLE:
    - gate=0, step_idx=0, tick counter=0.
    - run=1 -> PLAY, loading step 0.
  - PLAY:
    - gate = latched_on.
    - When tick == STEP_TICKS-GAP_TICKS-1: go to GAP if GAP_TICKS>0. Otherwise stay in PLAY until the step boundary.
  - GAP:
    - gate=0.
    - At the step boundary -> PLAY with the next step.
  - run=0 in PLAY or GAP -> IDLE.
- Step boundary: tick == STEP_TICKS-1.
  - tick -> 0.
  - step_idx -> step_idx+1, wrapping NUM_STEPS-1 -> 0.
  - The new slot's {on, note} is latched.
  - step_pulse=1.
- `note` is latched at step entry and holds for the whole step. It also holds its last value in IDLE and GAP, so the decoder input does not glitch.
- Write/latch collision: a write to the slot being latched in the same cycle is not seen. The latch reads the pre-write contents, and the new value plays on the next pass.
- A write to the current step during play does not change `note` or `gate` until that slot is entered again.
- Tick counter is 32-bit unsigned and never exceeds STEP_TICKS-1.

## Timing
- Reset values: note=0, gate=0, step_idx=0, step_pulse=0, state=IDLE, pattern cleared. All outputs are registered.
- Start: run sampled 1 in IDLE at edge k. Outputs at k+1:
  - step_pulse=1, step_idx=0.
  - note=slot0.note, gate=slot0.on.
  - tick=0.
- Step length: exactly STEP_TICKS cycles between consecutive step_pulse strobes.
- Gate timing: high for STEP_TICKS-GAP_TICKS cycles starting at the step_pulse cycle, then low for GAP_TICKS cycles. This holds only for an enabled slot; for a rest the gate stays 0 for the whole step.
- Stop: run sampled 0 at edge k. Outputs at k+1:
  - gate=0, step_idx=0, step_pulse=0.
  - state=IDLE, any partial step is discarded.
  - run=1 again restarts at step 0 with the 1-cycle latency above.
- run toggled on the same edge as a step boundary: stop wins, and no step_pulse is emitted.
- rst_n low mid-step forces all reset values immediately (asynchronous). Release is synchronous to the next clk edge.

## Test plan
All scenarios use NUM_STEPS=4, STEP_TICKS=8, GAP_TICKS=2.
- Reset/idle: hold rst_n=0, then release with run=0 for 20 cycles -> note=0, gate=0, step_idx=0, step_pulse never asserted.
- Basic play:
  - Stimulus: write slots {1,000},{1,001},{1,011},{1,100}; assert run.
  - Required: step_pulse every 8 cycles; step_idx 0,1,2,3,0; note 000,001,011,100.
  - Required: gate high 6 cycles then low 2 cycles in each step.
- Rest slot: slot 2 = {0,110}, run -> gate=0 for all 8 cycles of step 2, note=110, step_pulse still fires.
- Stop/restart: deassert run in cycle 3 of step 2 -> next cycle gate=0, step_idx=0; reassert 5 cycles later -> step_pulse and step 0 after 1 cycle.
- Write collision:
  - Stimulus: write slot 1 = {1,111} on the exact cycle slot 1 is entered (old value {1,001}).
  - Required: note=001 for this pass, 111 on the next pass.
- Async reset mid-play: pull rst_n low in the GAP of step 3 -> outputs return to reset values with no clock edge; pattern reads back cleared (all steps silent after restart).

Source files
------------

// File: rtl/step_sequencer.sv
// Pattern step sequencer: plays NUM_STEPS programmable {on, note} slots at a fixed
// tempo, with a silent gap at the end of each step so repeated notes articulate.
module step_sequencer #(
  parameter int NUM_STEPS  = 8,
  parameter int STEP_TICKS = 3_000_000,
  parameter int GAP_TICKS  = 300_000,
  localparam int AW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_note,
  input  logic          wr_on,
  output logic [2:0]    note,
  output logic          gate,
  output logic [AW-1:0] step_idx,
  output logic          step_pulse
);

  localparam logic [31:0] LAST_TICK = 32'(STEP_TICKS - 1);
  localparam logic [31:0] GAP_START = 32'(STEP_TICKS - GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state_reg;
  logic [31:0]   tick_reg;
  logic [AW-1:0] step_idx_reg;
  logic [2:0]    note_reg;
  logic          gate_reg;
  logic          step_pulse_reg;

  // Entry layout is {on, note[2:0]}; held in registers so reset can clear every slot.
  logic [3:0]    pattern_reg [NUM_STEPS];
  logic [AW-1:0] next_idx;
  logic [3:0]    next_slot;
  logic [3:0]    first_slot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STEPS; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pattern_reg[gi] <= 4'b0000;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          pattern_reg[gi] <= {wr_on, wr_note};
        end
      end
    end
  endgenerate

  // The latch below reads the array before this edge's write lands, so a write to
  // the slot being entered is heard only on the next pass.
  assign next_idx   = step_idx_reg + AW'(1);
  assign next_slot  = pattern_reg[next_idx];
  assign first_slot = pattern_reg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tick_reg       <= 32'd0;
      step_idx_reg   <= '0;
      note_reg       <= 3'b000;
      gate_reg       <= 1'b0;
      step_pulse_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tick_reg     <= 32'd0;
          step_idx_reg <= '0;
          if (run) begin
            state_reg      <= PLAY;
            note_reg       <= first_slot[2:0];
            gate_reg       <= first_slot[3];
            step_pulse_reg <= 1'b1;
          end else begin
            gate_reg       <= 1'b0;
            step_pulse_reg <= 1'b0;
          end
        end
        default: begin
          if (!run) begin
            // Stop beats a coincident step boundary; note keeps its last value.
            state_reg      <= IDLE;
            tick_reg       <= 32'd0;
            step_idx_reg   <= '0;
            gate_reg       <= 1'b0;
            step_pulse_reg <= 1'b0;
          end else if (tick_reg == LAST_TICK) begin
            state_reg      <= PLAY;
            tick_reg       <= 32'd0;
            step_idx_reg   <= next_idx;
            note_reg       <= next_slot[2:0];
            gate_reg       <= next_slot[3];
            step_pulse_reg <= 1'b1;
          end else begin
            tick_reg       <= tick_reg + 32'd1;
            step_pulse_reg <= 1'b0;
            if (state_reg == PLAY && GAP_TICKS > 0 && tick_reg == GAP_START) begin
              state_reg <= GAP;
              gate_reg  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign note       = note_reg;
  assign gate       = gate_reg;
  assign step_idx   = step_idx_reg;
  assign step_pulse = step_pulse_reg;

endmodule
